data_memory_responder: RTL

- Memory-side responder for core data accesses: accepts one load/store request at a time over a valid/ready handshake and performs the byte-enabled word access on an internal RAM array.
- Returns read data or a write acknowledge over a second valid/ready channel.
- Adds programmable wait states so multicycle and pipelined cores can be exercised against a non-ideal data memory.
- Sits between the core's data port and the data address region.

---
 rtl/data_memory_responder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - byte-enabled data RAM responder with programmable wait states
module data_memory_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          ADDR_WIDTH  = 15,
  parameter int          WAIT_CYCLES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [3:0]  req_byteena,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int          DEPTH = 1 << ADDR_WIDTH;
  // One past the last valid byte address; 33 bits so the top of the map cannot wrap.
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'd4 << ADDR_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [7:0]  r_count;
  logic        r_write;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_error;

  logic [31:0] r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_access;
  logic                  w_in_range;
  logic [32:0]           w_offset;
  logic [ADDR_WIDTH-1:0] w_index;
  logic [31:0]           w_lane_mask;
  logic [31:0]           w_rd_masked;
  logic                  w_unused_bits;

  assign w_offset      = {1'b0, r_addr} - {1'b0, BASE_ADDR};
  assign w_in_range    = (r_addr >= BASE_ADDR) && ({1'b0, r_addr} < LIMIT);
  assign w_index       = w_offset[ADDR_WIDTH+1:2];
  assign w_unused_bits = ^{w_offset[32:ADDR_WIDTH+2], w_offset[1:0]};

  assign w_lane_mask = {{8{r_be[3]}}, {8{r_be[2]}}, {8{r_be[1]}}, {8{r_be[0]}}};
  assign w_rd_masked = r_mem[w_index] & w_lane_mask;

  assign rsp_rdata = r_rdata;
  assign rsp_error = r_error;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs; ready/valid depend on state only.
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    w_accept     = 1'b0;
    w_access     = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_count == 8'd0) begin
          w_access     = 1'b1;
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Request capture, wait countdown and registered response data.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= 8'd0;
      r_write <= 1'b0;
      r_addr  <= 32'd0;
      r_be    <= 4'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_error <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_address;
        r_be    <= req_byteena;
        r_wdata <= req_wdata;
        r_count <= 8'(WAIT_CYCLES);
      end else if (r_state == S_WAIT && r_count != 8'd0) begin
        r_count <= r_count - 8'd1;
      end
      if (w_access) begin
        r_rdata <= (w_in_range && !r_write) ? w_rd_masked : 32'd0;
        r_error <= !w_in_range;
      end
    end
  end

  // Array write port; reset on the access edge suppresses the store.
  always_ff @(posedge clock) begin
    if (!reset && w_access && r_write && w_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) begin
          r_mem[w_index][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
